serial_seq_ctrl: RTL and testbench

Parametrised sequencer for the bit-serial CPU datapath. It accepts one instruction per button press, latches the opcode, and drives the serial ALU, register shifter and accumulator for exactly WIDTH bit-cycles using an internal bit counter. It then commits the result, holds the output strobe for a configurable number of cycles, and reports completion. It sits between the instruction-load / button-edge logic and the shift-register / ALU / accumulator datapath.

---
 rtl/serial_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_serial_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_ctrl.sv
// Bit-serial CPU sequencer: accepts an instruction, drives the serial datapath for WIDTH
// bit-cycles, commits, holds out_en, then pulses done. Define SERIAL_CTRL_STEP_EN for step gating.
module serial_seq_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned OUT_CYCLES = 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [3:0]                                    opcode,
   input  logic                                          inst_done,
   input  logic                                          btn_edge,
`ifdef SERIAL_CTRL_STEP_EN
   input  logic                                          step,
`endif
   output logic                                          busy,
   output logic                                          done,
   output logic                                          err,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_idx,
   output logic [2:0]                                    alu_op,
   output logic                                          alu_start,
   output logic                                          carry_init,
   output logic                                          alu_en,
   output logic                                          reg_shift_en,
   output logic                                          acc_write_en,
   output logic                                          acc_load_en,
   output logic                                          reg_store_en,
   output logic                                          out_en
);

   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
   localparam logic [3:0] HoldLast = 4'(OUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StDecode, StShift, StWrite, StOutput} state_t;

   state_t        state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [3:0]    hold_q, hold_d;
   logic          err_q, err_d;
   logic          done_q, done_d;

   logic       dec_alu, dec_load, dec_store, dec_ill;
   logic [2:0] dec_op;
   logic       adv;

`ifdef SERIAL_CTRL_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   always_comb begin
      dec_alu   = 1'b1;
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_ill   = 1'b0;
      dec_op    = 3'b000;
      case (op_q)
         4'b0000, 4'b1000: dec_op = 3'b000;
         4'b0001, 4'b1001: dec_op = 3'b001;
         4'b0110, 4'b1100: dec_op = 3'b010;
         4'b0101, 4'b1011: dec_op = 3'b011;
         4'b0100, 4'b1010: dec_op = 3'b100;
         4'b0010:          dec_op = 3'b101;
         4'b0011:          dec_op = 3'b110;
         4'b0111, 4'b1101: begin
            dec_alu  = 1'b0;
            dec_load = 1'b1;
         end
         4'b1110: begin
            dec_alu   = 1'b0;
            dec_store = 1'b1;
         end
         default: begin
            dec_alu = 1'b0;
            dec_ill = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      err_d        = err_q;
      done_d       = 1'b0;
      alu_start    = 1'b0;
      alu_en       = 1'b0;
      reg_shift_en = 1'b0;
      acc_write_en = 1'b0;
      acc_load_en  = 1'b0;
      reg_store_en = 1'b0;
      out_en       = 1'b0;
      case (state_q)
         StIdle: begin
            if (btn_edge && inst_done) begin
               op_d    = opcode;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (dec_alu) begin
               // Bit 0 is processed here, so SHIFT starts at bit 1
               alu_start    = 1'b1;
               alu_en       = 1'b1;
               reg_shift_en = 1'b1;
               acc_write_en = 1'b1;
               if (WIDTH > 1) begin
                  cnt_d   = BW'(1);
                  state_d = StShift;
               end else begin
                  state_d = StWrite;
               end
            end else begin
               acc_load_en  = dec_load;
               reg_store_en = dec_store;
               if (dec_ill) err_d = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StShift: begin
            if (adv) begin
               alu_en       = 1'b1;
               reg_shift_en = 1'b1;
               acc_write_en = 1'b1;
               if (cnt_q == BitLast) state_d = StWrite;
               else                  cnt_d   = cnt_q + BW'(1);
            end
         end
         StWrite: begin
            alu_en       = 1'b1;
            acc_write_en = 1'b1;
            hold_d       = '0;
            state_d      = StOutput;
         end
         StOutput: begin
            out_en = 1'b1;
            if (hold_q == HoldLast) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign err        = err_q;
   assign bit_idx    = cnt_q;
   assign alu_op     = busy ? dec_op : 3'b000;
   assign carry_init = busy && dec_alu && (dec_op == 3'b001);

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Randomised self-checking bench for serial_seq_ctrl: two instances (WIDTH=8/OUT=1 and
// WIDTH=1/OUT=3) compared cycle by cycle against a timeline built from the opcode rules.
module tb_serial_seq_ctrl;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] bit_idx;
      logic [2:0] alu_op;
      logic       alu_start;
      logic       carry_init;
      logic       alu_en;
      logic       reg_shift_en;
      logic       acc_write_en;
      logic       acc_load_en;
      logic       reg_store_en;
      logic       out_en;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] opcode;
   logic       inst_done, btn0, btn1, step;

   logic       busy0, done0, err0, alu_start0, carry0, alu_en0, shift0, accw0, load0, store0;
   logic       out0;
   logic [2:0] bit_idx0, alu_op0;
   logic       busy1, done1, err1, alu_start1, carry1, alu_en1, shift1, accw1, load1, store1;
   logic       out1;
   logic [0:0] bit_idx1;
   logic [2:0] alu_op1;

   int   checks = 0;
   int   failures = 0;
   rec_t exp_q[$];
   bit   steps [0:63];
   bit   exp_err [2];
   // ALU code per opcode, -1 for load/store/illegal
   int   alu_tab [16] = '{0, 1, 5, 6, 4, 3, 2, -1, 0, 1, 4, 3, 2, -1, -1, -1};

   always #5 clk = ~clk;

   serial_seq_ctrl #(.WIDTH(8), .OUT_CYCLES(1)) u0 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .inst_done(inst_done), .btn_edge(btn0),
`ifdef SERIAL_CTRL_STEP_EN
      .step(step),
`endif
      .busy(busy0), .done(done0), .err(err0), .bit_idx(bit_idx0), .alu_op(alu_op0),
      .alu_start(alu_start0), .carry_init(carry0), .alu_en(alu_en0), .reg_shift_en(shift0),
      .acc_write_en(accw0), .acc_load_en(load0), .reg_store_en(store0), .out_en(out0)
   );

   serial_seq_ctrl #(.WIDTH(1), .OUT_CYCLES(3)) u1 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .inst_done(inst_done), .btn_edge(btn1),
`ifdef SERIAL_CTRL_STEP_EN
      .step(step),
`endif
      .busy(busy1), .done(done1), .err(err1), .bit_idx(bit_idx1), .alu_op(alu_op1),
      .alu_start(alu_start1), .carry_init(carry1), .alu_en(alu_en1), .reg_shift_en(shift1),
      .acc_write_en(accw1), .acc_load_en(load1), .reg_store_en(store1), .out_en(out1)
   );

   function automatic rec_t obs(input int sel);
      rec_t r;
      r = '0;
      if (sel == 0) begin
         r.busy = busy0; r.done = done0; r.err = err0; r.bit_idx = 8'(bit_idx0);
         r.alu_op = alu_op0; r.alu_start = alu_start0; r.carry_init = carry0;
         r.alu_en = alu_en0; r.reg_shift_en = shift0; r.acc_write_en = accw0;
         r.acc_load_en = load0; r.reg_store_en = store0; r.out_en = out0;
      end else begin
         r.busy = busy1; r.done = done1; r.err = err1; r.bit_idx = 8'(bit_idx1);
         r.alu_op = alu_op1; r.alu_start = alu_start1; r.carry_init = carry1;
         r.alu_en = alu_en1; r.reg_shift_en = shift1; r.acc_write_en = accw1;
         r.acc_load_en = load1; r.reg_store_en = store1; r.out_en = out1;
      end
      return r;
   endfunction

   task automatic set_btn(input int sel, input logic v);
      if (sel == 0) btn0 = v;
      else          btn1 = v;
   endtask

   // mode 0: always step, 1: alternate (stall first), 2: random; ignored without step gating
   task automatic fill_steps(input int mode);
      for (int c = 0; c < 64; c++) begin
`ifdef SERIAL_CTRL_STEP_EN
         if (mode == 1)      steps[c] = (c % 2 == 1);
         else if (mode == 2) steps[c] = (c >= 32) ? 1'b1 : 1'($urandom);
         else                steps[c] = 1'b1;
`else
         steps[c] = 1'b1;
`endif
      end
   endtask

   // Expected per-cycle outputs from cycle 1 (first cycle after accept) through the done cycle
   task automatic build(input int sel, input logic [3:0] op, input int w, input int o);
      rec_t r;
      int   a, c;
      bit   adv;
      exp_q.delete();
      a = alu_tab[op];
      r = '0;
      r.busy = 1'b1;
      if (a < 0) begin
         r.acc_load_en  = (op == 4'd7) || (op == 4'd13);
         r.reg_store_en = (op == 4'd14);
         exp_q.push_back(r);
         exp_err[sel] = (op == 4'd15);
         r = '0;
         r.done = 1'b1;
         r.err  = exp_err[sel];
         exp_q.push_back(r);
      end else begin
         r.alu_op = 3'(a); r.carry_init = (a == 1);
         r.alu_start = 1'b1; r.alu_en = 1'b1; r.reg_shift_en = 1'b1; r.acc_write_en = 1'b1;
         exp_q.push_back(r);
         r.alu_start = 1'b0;
         c = 2;
         for (int b = 1; b < w; b++) begin
            do begin
               adv = steps[c];
               r.bit_idx = 8'(b);
               r.alu_en = adv; r.reg_shift_en = adv; r.acc_write_en = adv;
               exp_q.push_back(r);
               c++;
            end while (!adv);
         end
         r.bit_idx = 8'(w - 1);
         r.alu_en = 1'b1; r.acc_write_en = 1'b1; r.reg_shift_en = 1'b0;
         exp_q.push_back(r);
         r.alu_en = 1'b0; r.acc_write_en = 1'b0; r.out_en = 1'b1;
         repeat (o) exp_q.push_back(r);
         exp_err[sel] = 1'b0;
         r = '0;
         r.done = 1'b1;
         exp_q.push_back(r);
      end
   endtask

   // Runs one instruction on instance sel; starts and ends just after a falling edge.
   task automatic run_instr(input int sel, input logic [3:0] op, input logic [3:0] op_after,
                            input bit noise, input bit pre, input bit chain,
                            input logic [3:0] next_op, input int abort_at, input int n_idle,
                            input string name);
      rec_t e, o;
      int   n;
      build(sel, op, (sel == 0) ? 8 : 1, (sel == 0) ? 1 : 3);
      n = exp_q.size();
      if (!pre) begin
         opcode = op; inst_done = 1'b1; set_btn(sel, 1'b1);
      end
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         set_btn(sel, 1'b0);
         opcode    = op_after;
         step      = steps[c];
         inst_done = 1'($urandom);
         if (noise && c < n && (abort_at == 0 || c < abort_at)) set_btn(sel, 1'($urandom));
         if (abort_at != 0 && c == abort_at) rst_n = 1'b0;
         if (chain && c == n) begin
            set_btn(sel, 1'b1); opcode = next_op; inst_done = 1'b1;
         end
         @(negedge clk);
         e = exp_q[c-1];
         o = obs(sel);
         if (abort_at != 0 && c > abort_at) e = '0;
         else if (e.busy == 1'b0) o.bit_idx = '0;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL %s sel=%0d cycle=%0d actual=%h required=%h", name, sel, c, o, e);
         end
         if (abort_at != 0 && c == abort_at + 1) rst_n = 1'b1;
         if (abort_at != 0 && c == abort_at + 3) break;
      end
      if (abort_at != 0) exp_err[sel] = 1'b0;
      for (int i = 0; i < n_idle; i++) begin
         @(posedge clk); #1;
         set_btn(sel, 1'b0);
         inst_done = 1'($urandom);
         @(negedge clk);
         e = '0;
         e.err = exp_err[sel];
         o = obs(sel);
         o.bit_idx = '0;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL %s_idle sel=%0d idle=%0d actual=%h required=%h", name, sel, i, o, e);
         end
      end
   endtask

   task automatic test_reset();
      rec_t o;
      rst_n = 1'b0; btn0 = 1'b0; btn1 = 1'b0; opcode = 4'hf; inst_done = 1'b1; step = 1'b1;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            o = obs(s);
            checks++;
            if (o !== '0) begin
               failures++;
               $display("FAIL reset sel=%0d step=%0d actual=%h required=0", s, k, o);
            end
         end
         rst_n = 1'b1;
      end
      exp_err[0] = 1'b0;
      exp_err[1] = 1'b0;
   endtask

   task automatic test_alu_basic();
      fill_steps(0);
      run_instr(0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 2, "add_w8");
   endtask

   task automatic test_opcode_hold();
      fill_steps(0);
      run_instr(0, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "subi_hold");
   endtask

   task automatic test_store_illegal();
      fill_steps(0);
      run_instr(0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "store");
      run_instr(0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4, "illegal");
      run_instr(0, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "err_clear");
      run_instr(0, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "load");
   endtask

   task automatic test_btn_ignored_reset();
      fill_steps(0);
      run_instr(0, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0, 0, 1, "btn_ignored");
      run_instr(0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0, 4, 0, "abort");
   endtask

   task automatic test_no_accept();
      for (int k = 0; k < 2; k++) begin
         opcode = 4'($urandom);
         btn0 = (k == 0); inst_done = (k != 0);
         @(posedge clk); #1;
         btn0 = 1'b0;
         @(negedge clk);
         checks++;
         if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL no_accept k=%0d busy=%b done=%b required busy=0 done=0",
                     k, busy0, done0);
         end
      end
   endtask

   task automatic test_width1();
      fill_steps(0);
      run_instr(1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "w1_add");
      run_instr(1, 4'b0011, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd0, 0, 1, "w1_srli");
   endtask

   task automatic test_step();
`ifdef SERIAL_CTRL_STEP_EN
      fill_steps(1);
      run_instr(0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1, "step_alt");
      fill_steps(2);
      run_instr(0, 4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0, 4'd0, 0, 1, "step_rand");
`endif
   endtask

   task automatic test_back_to_back();
      fill_steps(0);
      run_instr(0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0111, 0, 0, "b2b_or");
      run_instr(0, 4'b0111, 4'b0111, 1'b0, 1'b1, 1'b1, 4'b1111, 0, 0, "b2b_load");
      run_instr(0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0010, 0, 0, "b2b_illegal");
      run_instr(0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1, "b2b_slli");
   endtask

   task automatic test_random();
      int sel;
      for (int k = 0; k < 30; k++) begin
         sel = int'($urandom_range(1, 0));
         fill_steps(2);
         run_instr(sel, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, 4'd0, 0,
                   int'($urandom_range(2, 0)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_alu_basic();
      test_opcode_hold();
      test_store_illegal();
      test_btn_ignored_reset();
      test_no_accept();
      test_width1();
      test_step();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
